// File: rtl/sid_bus_sched.sv
// SID write scheduler: round-robin merge of two write ports into a FIFO,
// drained onto the SID bus at most one write per 1 MHz TICK.
module sid_bus_sched #(
  parameter int CLK_DIV    = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          A_VALID,
  output logic                          A_READY,
  input  logic [4:0]                    A_ADDR,
  input  logic [7:0]                    A_DATA,
  input  logic                          B_VALID,
  output logic                          B_READY,
  input  logic [4:0]                    B_ADDR,
  input  logic [7:0]                    B_DATA,
  output logic                          TICK,
  output logic                          WR,
  output logic [4:0]                    ADDR,
  output logic [7:0]                    DATA,
  output logic                          DROPPED,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [4:0] ADDR_LIM = 5'h19;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;
  port_e         last_q, last_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [12:0]   mem_q [FIFO_DEPTH];
  logic [12:0]   mem_d [FIFO_DEPTH];
  logic          wr_q, wr_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          dropped_q, dropped_d;

  logic        full, empty;
  logic        grant_a, grant_b;
  logic        xfer_a, xfer_b, xfer;
  logic [4:0]  in_addr;
  logic [7:0]  in_data;
  logic        in_ok;
  logic        push, pop;
  logic [12:0] head;

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  // Tie goes to the port not served last.
  assign grant_a = A_VALID && (!B_VALID || last_q == PORT_B);
  assign grant_b = B_VALID && (!A_VALID || last_q == PORT_A);
  assign A_READY = grant_a && !full;
  assign B_READY = grant_b && !full;

  assign xfer_a  = A_VALID && A_READY;
  assign xfer_b  = B_VALID && B_READY;
  assign xfer    = xfer_a || xfer_b;
  assign in_addr = xfer_a ? A_ADDR : B_ADDR;
  assign in_data = xfer_a ? A_DATA : B_DATA;
  assign in_ok   = (in_addr < ADDR_LIM);

  assign push = xfer && in_ok;
  assign pop  = tick_q && !empty;
  assign head = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    if (div_cnt_q == DIV_MAX) begin
      div_cnt_d = '0;
    end
    tick_d    = (div_cnt_q == DIV_MAX);
    last_d    = last_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    wr_d      = pop;
    addr_d    = addr_q;
    data_d    = data_q;
    dropped_d = xfer && !in_ok;
    if (xfer_a) begin
      last_d = PORT_A;
    end else if (xfer_b) begin
      last_d = PORT_B;
    end
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = {in_addr, in_data};
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
      addr_d = head[12:8];
      data_d = head[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      last_q    <= PORT_B;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      last_q    <= last_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dropped_q <= dropped_d;
    end
  end

  // Storage needs no reset: pointers alone define valid entries.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign TICK    = tick_q;
  assign WR      = wr_q;
  assign ADDR    = addr_q;
  assign DATA    = data_q;
  assign DROPPED = dropped_q;
  assign LEVEL   = wptr_q - rptr_q;

endmodule

// File: doc/sid_bus_sched.md
# sid_bus_sched

Write scheduler and 1 MHz timebase for the SID core. Two requesters (host port A, player port B) submit register writes through valid/ready handshakes. A round-robin arbiter merges them into one FIFO. The FIFO drains to the SID WR/ADDR/DATA bus at most one write per TICK, so the voice and envelope decoders never see back-to-back writes inside one SID cycle.

## Interface
Parameters:
- CLK_DIV, 12: master clocks per TICK period (12 MHz CLK -> 1 MHz); legal range >= 2.
- FIFO_DEPTH, 8: write-queue entries; power of two, >= 2.

Ports:
- CLK  in  1  master clock; one clock domain.
- RST  in  1  reset; synchronous, active-high.
- A_VALID  in  1  port A write request.
- A_READY  out  1  port A accepted this cycle (combinational).
- A_ADDR  in  5  port A register address.
- A_DATA  in  8  port A register data.
- B_VALID, B_READY, B_ADDR, B_DATA: same as port A, for port B.
- TICK  out  1  1 MHz enable, one CLK cycle wide; drives SID TICK.
- WR  out  1  SID write strobe, one CLK cycle wide.
- ADDR  out  5  SID address bus.
- DATA  out  8  SID data bus.
- DROPPED  out  1  one-cycle pulse: an accepted write was discarded.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Timebase:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - TICK is registered; it is high in the cycle after div_cnt == CLK_DIV-1.
- Arbitration:
  - Pointer `last` records the port served most recently.
  - Only one port valid: that port is granted.
  - Both ports valid: the port other than `last` is granted.
  - X_READY = grant_X && !full.
  - Transfer occurs when X_VALID && X_READY. On transfer, `last` is set to X.
  - At most one transfer per cycle.
- Filter:
  - A transfer with ADDR >= 5'h19 (SID read-only/unused range) completes the handshake but is not enqueued.
  - DROPPED pulses high the next cycle.
  - `last` still updates.
- FIFO:
  - Entries are {addr[4:0], data[7:0]}, 13 bits.
  - Read and write pointers carry one extra wrap bit.
  - full is (ptrs equal except MSB); empty is (ptrs equal).
- Issue:
  - In a cycle where TICK is high and the FIFO is not empty (evaluated on the registered state of that cycle), the head entry is popped.
  - Next cycle: WR=1 with ADDR/DATA equal to the popped entry.
  - Any cycle without a pop: WR=0; ADDR/DATA hold their last value.
- States per port: IDLE (no valid), WAIT (valid, not granted or full), XFER (handshake). No other FSM; the issue path is TICK-gated pop.

## Timing
- Reset values, next cycle after RST high:
  - TICK=0, WR=0, ADDR=0, DATA=0, DROPPED=0, LEVEL=0.
  - A_READY/B_READY follow the combinational rule, i.e. 1 when the port is valid.
  - div_cnt=0, FIFO empty, `last`=B (A wins first tie).
- First TICK after reset release is high in post-reset cycle CLK_DIV+1. Afterwards TICK repeats every CLK_DIV cycles.
- Latency:
  - Enqueue at cycle n makes the entry visible at n+1.
  - Entry is popped at the first TICK cycle >= n+1 when it is head.
  - WR follows the pop cycle by 1. No fall-through: push and TICK in the same cycle on an empty FIFO issues on the next TICK.
- Full FIFO: READY=0 for both ports even when a pop occurs that cycle. The push is accepted the following cycle.
- Push and pop in the same cycle when neither full nor empty: LEVEL is unchanged.
- Throughput bound: WR pulses are >= CLK_DIV cycles apart.
- RST mid-operation:
  - Queued entries are lost; WR is 0 the next cycle.
  - A pending handshake is not completed; a requester must re-present.
- VALID may drop without a transfer; ADDR/DATA are sampled only at transfer.

## Test plan
- Reset, CLK_DIV=12, no requests -> TICK high at post-reset cycles 13, 25, 37; WR never high; LEVEL=0.
- A writes {0x01, 0x44} once -> WR=1 one cycle after the next TICK with ADDR=0x01, DATA=0x44; LEVEL returns 0.
- A and B valid continuously with distinct data -> accept order A,B,A,B…; FIFO fills to 8; both READY=0 until a TICK pop; WR pulses spaced exactly 12 cycles, data in accept order.
- B writes ADDR=0x1B -> B_READY=1, DROPPED pulses next cycle, LEVEL stays 0, no WR.
- Enqueue exactly on a TICK cycle with FIFO empty -> no WR until one cycle after the following TICK.
- RST asserted with LEVEL=5 -> next cycle LEVEL=0, WR=0, TICK=0; first post-reset TICK at cycle 13.
